// File: rtl/ifir_2nd_stage_decim.sv
// ifir_2nd_stage_decim
//   Full-parallel 2:1 polyphase decimating FIR. Accepts one 24-bit signed
//   sample per qualified clock_in edge and emits one filtered sample per
//   accepted pair. It uses the same 16-tap symmetric coefficient set and
//   output scaling as the 2x interpolating second IFIR stage, so the two
//   stages are gain-matched.
//
// Ports
//   clock_in   in   1   high-rate clock, rising edge
//   rstn       in   1   asynchronous assert, active-low reset
//   din        in  24   signed input sample
//   din_valid  in   1   din is accepted on a rising edge where this is high
//   sync_in    in   1   single-cycle pulse that realigns the decimation phase
//   dout       out 24   signed decimated output, held between updates
//   dout_valid out  1   one-cycle strobe marking a new dout
//   phase      out  1   registered phase state (0 = next sample is EVEN)
//
// Handshake: din is consumed on every rising edge with din_valid high; there
// is no back-pressure. dout_valid is a pure strobe with no ready; the
// consumer must take dout on the cycle it is high (dout stays held anyway).
module ifir_2nd_stage_decim #(
  parameter logic signed [27:0] COEF_B1 = 28'h0000041,
  parameter logic signed [27:0] COEF_B2 = 28'h0001041,
  parameter logic signed [27:0] COEF_B3 = 28'h0001040,
  parameter logic signed [27:0] COEF_B4 = 28'h0021044,
  parameter logic signed [27:0] COEF_B5 = 28'h0081021,
  parameter logic signed [27:0] COEF_B6 = 28'h0000401,
  parameter logic signed [27:0] COEF_B7 = 28'h0480048,
  parameter logic signed [27:0] COEF_B8 = 28'h1202004
) (
  input  logic        clock_in,
  input  logic        rstn,
  input  logic [23:0] din,
  input  logic        din_valid,
  input  logic        sync_in,
  output logic [23:0] dout,
  output logic        dout_valid,
  output logic        phase
);

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_t;

  // Half of the symmetric impulse response; COEFS[k] weights x[k] and x[15-k].
  localparam logic [7:0][27:0] COEFS = {COEF_B8, COEF_B7, COEF_B6, COEF_B5,
                                        COEF_B4, COEF_B3, COEF_B2, COEF_B1};

  // Delay line, x[0] in the low slice so a shift is a plain concatenation.
  logic [15:0][23:0] r_x;
  state_t            r_state;
  logic              r_calc_pending;
  logic [23:0]       r_dout;
  logic              r_dout_valid;

  state_t            w_state_next;
  logic              w_pair_done;
  logic signed [24:0] w_pre  [8];
  logic signed [52:0] w_prod [8];
  logic signed [55:0] w_sum;

  // ---------------------------------------------------------------------------
  // Phase FSM: next-state logic. sync_in alone forces EVEN; sync_in with a
  // sample makes that sample the EVEN one. Only a plain ODD acceptance
  // completes a pair.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pair_done  = 1'b0;
    if (din_valid) begin
      if (sync_in) begin
        w_state_next = S_ODD;
      end else if (r_state == S_EVEN) begin
        w_state_next = S_ODD;
      end else begin
        w_state_next = S_EVEN;
        w_pair_done  = 1'b1;
      end
    end else if (sync_in) begin
      w_state_next = S_EVEN;
    end
  end

  always_ff @(posedge clock_in or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_EVEN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line: shifts only on accepted samples.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge rstn) begin
    if (!rstn) begin
      r_x <= '0;
    end else if (din_valid) begin
      r_x <= {r_x[14:0], din};
    end
  end

  // ---------------------------------------------------------------------------
  // Symmetric pre-add (25 bits, exact) then full-precision products.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 8; g++) begin : g_tap
    assign w_pre[g]  = {r_x[g][23], r_x[g]} + {r_x[15-g][23], r_x[15-g]};
    assign w_prod[g] = 53'(w_pre[g]) * 53'($signed(COEFS[g]));
  end

  always_comb begin
    w_sum = 56'(w_prod[0]) + 56'(w_prod[1]) + 56'(w_prod[2]) + 56'(w_prod[3]) +
            56'(w_prod[4]) + 56'(w_prod[5]) + 56'(w_prod[6]) + 56'(w_prod[7]);
  end

  // ---------------------------------------------------------------------------
  // Compute stage. The pending flag lives for exactly one cycle: the edge
  // after the ODD acceptance consumes it. The next acceptance after an ODD
  // one is always treated as EVEN, so a new pair can never set the flag on
  // the same edge that consumes it, and sync_in never touches it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge rstn) begin
    if (!rstn) begin
      r_calc_pending <= 1'b0;
      r_dout         <= '0;
      r_dout_valid   <= 1'b0;
    end else begin
      r_calc_pending <= w_pair_done;
      r_dout_valid   <= r_calc_pending;
      if (r_calc_pending) begin
        // Truncating scale: no rounding, wraps on overflow.
        r_dout <= w_sum[35:12];
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign phase      = r_state;

endmodule

// File: tb/tb_ifir_2nd_stage_decim.sv
// Testbench for ifir_2nd_stage_decim: directed steps with a reference model
// that pushes expected outputs (value and arrival cycle) into a queue; a
// monitor pops and compares on each dout_valid.
module tb_ifir_2nd_stage_decim;

  localparam logic signed [27:0] B1 = 28'h0000041;
  localparam logic signed [27:0] B2 = 28'h0001041;
  localparam logic signed [27:0] B3 = 28'h0001040;
  localparam logic signed [27:0] B4 = 28'h0021044;
  localparam logic signed [27:0] B5 = 28'h0081021;
  localparam logic signed [27:0] B6 = 28'h0000401;
  localparam logic signed [27:0] B7 = 28'h0480048;
  localparam logic signed [27:0] B8 = 28'h1202004;

  logic        clock_in = 1'b0;
  logic        rstn;
  logic [23:0] din;
  logic        din_valid;
  logic        sync_in;
  logic [23:0] dout;
  logic        dout_valid;
  logic        phase;

  ifir_2nd_stage_decim #(
    .COEF_B1(B1), .COEF_B2(B2), .COEF_B3(B3), .COEF_B4(B4),
    .COEF_B5(B5), .COEF_B6(B6), .COEF_B7(B7), .COEF_B8(B8)
  ) dut (
    .clock_in  (clock_in),
    .rstn      (rstn),
    .din       (din),
    .din_valid (din_valid),
    .sync_in   (sync_in),
    .dout      (dout),
    .dout_valid(dout_valid),
    .phase     (phase)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  // ---------------- counters and scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [23:0] got_q[$];
  logic [23:0] ref_q[$];

  // ---------------- reference model ----------------
  logic signed [27:0] h [16];
  logic signed [23:0] mx [16];
  logic               mph;

  logic [23:0] even_tbl [9];
  logic [23:0] odd_tbl  [9];
  logic [23:0] data_tbl [20];

  function automatic logic [23:0] model_out();
    logic signed [55:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      s = s + 56'(mx[k]) * 56'(h[k]);
    end
    return s[35:12];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle. Called right after a falling edge; the model predicts the
  // effect of the coming rising edge before it happens.
  task automatic step(input logic [23:0] d, input logic v, input logic s);
    din       = d;
    din_valid = v;
    sync_in   = s;
    if (v) begin
      for (int k = 15; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = d;
      if (s || !mph) begin
        mph = 1'b1;
      end else begin
        mph = 1'b0;
        exp_q.push_back(model_out());
        exp_cyc_q.push_back(cyc + 2);
      end
    end else if (s) begin
      mph = 1'b0;
    end
    @(posedge clock_in);
    @(negedge clock_in);
    din_valid = 1'b0;
    sync_in   = 1'b0;
    chk("phase", {31'd0, phase}, {31'd0, mph});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(24'($urandom), 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clock_in);
    chk(tag, exp_q.size(), 0);
  endtask

  // Assert reset at a falling edge (mid-stream), check outputs before any
  // rising edge, flush the model, release after two cycles.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_dout", {8'd0, dout}, 0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 0);
    chk("rst_phase", {31'd0, phase}, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    got_q.delete();
    for (int k = 0; k < 16; k++) mx[k] = '0;
    mph = 1'b0;
    repeat (2) @(negedge clock_in);
    rstn = 1'b1;
  endtask

  task automatic impulse(input int lead_zeros);
    for (int i = 0; i < lead_zeros; i++) step(24'h0, 1'b1, 1'b0);
    step(24'h000100, 1'b1, 1'b0);
    for (int i = 0; i < 17 - lead_zeros; i++) step(24'h0, 1'b1, 1'b0);
  endtask

  task automatic check_tbl(input string tag, input logic [23:0] tbl [9]);
    logic [23:0] obs;
    chk({tag, "_count"}, got_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      obs = (got_q.size() > 0) ? got_q.pop_front() : 24'hxxxxxx;
      chk(tag, {8'd0, obs}, {8'd0, tbl[i]});
    end
    got_q.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock_in) begin
    if (rstn && dout_valid) begin
      got_q.push_back(dout);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        chk("dout", {8'd0, dout}, {8'd0, exp_q.pop_front()});
        chk("valid_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    h = '{B1, B2, B3, B4, B5, B6, B7, B8, B8, B7, B6, B5, B4, B3, B2, B1};
    even_tbl = '{24'h104, 24'h2104, 24'h40, 24'h120200, 24'h48004,
                 24'h8102, 24'h104, 24'h4, 24'h0};
    odd_tbl  = '{24'h4, 24'h104, 24'h8102, 24'h48004, 24'h120200,
                 24'h40, 24'h2104, 24'h104, 24'h0};
    for (int k = 0; k < 16; k++) mx[k] = '0;
    mph       = 1'b0;
    rstn      = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sync_in   = 1'b0;

    // Power-on reset values, before any clock edge.
    #1;
    chk("por_dout", {8'd0, dout}, 0);
    chk("por_dout_valid", {31'd0, dout_valid}, 0);
    chk("por_phase", {31'd0, phase}, 0);
    repeat (2) @(negedge clock_in);
    rstn = 1'b1;
    @(negedge clock_in);

    // Even impulse, valid held high.
    impulse(0);
    drain("even_drain");
    check_tbl("even_imp", even_tbl);

    // Odd impulse: one leading zero.
    impulse(1);
    drain("odd_drain");
    check_tbl("odd_imp", odd_tbl);

    // Sync alone after a single accepted sample realigns to EVEN.
    step(24'h0, 1'b1, 1'b0);
    step(24'h0, 1'b0, 1'b1);
    chk("sync_alone_phase", {31'd0, phase}, 0);
    impulse(0);
    drain("sync_drain");
    check_tbl("sync_imp", even_tbl);

    // Sync with a sample while in ODD: sample becomes EVEN, phase goes to 1.
    step(24'h123456, 1'b1, 1'b0);
    step(24'h654321, 1'b1, 1'b1);
    chk("sync_valid_phase", {31'd0, phase}, 1);
    step(24'hABCDEF, 1'b1, 1'b0);
    // Sync right after an ODD acceptance must not cancel the pending output.
    step(24'h000000, 1'b0, 1'b1);
    drain("sync_pending_drain");
    got_q.delete();

    // Gap-free reference run with random signed data.
    for (int i = 0; i < 20; i++) data_tbl[i] = 24'($urandom_range(0, 24'hFFFFFF));
    do_reset();
    @(negedge clock_in);
    for (int i = 0; i < 20; i++) step(data_tbl[i], 1'b1, 1'b0);
    drain("nogap_drain");
    ref_q = got_q;
    got_q.delete();

    // Same data with random 0-5 cycle gaps; timing checked by the monitor.
    do_reset();
    @(negedge clock_in);
    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(0, 5));
      step(data_tbl[i], 1'b1, 1'b0);
    end
    drain("gap_drain");
    chk("gap_count", got_q.size(), ref_q.size());
    for (int i = 0; i < 10; i++) begin
      chk("gap_vs_nogap", {8'd0, (got_q.size() > 0) ? got_q.pop_front() : 24'hxxxxxx},
          {8'd0, (ref_q.size() > 0) ? ref_q.pop_front() : 24'hxxxxxx});
    end

    // Wrap: full-scale positive input overflows the output window.
    for (int i = 0; i < 18; i++) step(24'h7FFFFF, 1'b1, 1'b0);
    drain("wrap_drain");
    got_q.delete();

    // Reset mid-pair with an output pending: it must be discarded, and the
    // next output needs two fresh samples.
    step(24'h100000, 1'b1, 1'b0);
    step(24'h200000, 1'b1, 1'b0);
    do_reset();
    @(negedge clock_in);
    step(24'h000100, 1'b1, 1'b0);
    idle(3);
    chk("post_reset_no_valid", exp_q.size(), 0);
    step(24'h0, 1'b1, 1'b0);
    drain("post_reset_drain");
    chk("post_reset_outputs", got_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
